// File: rtl/gpio_cond_pkg.sv
// Shared defaults and helpers for the GPIO conditioner front end.
package gpio_cond_pkg;

    localparam int DEF_NUM_PINS        = 17;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_RST_STAGES      = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One pin's synchronizer, debounce counter, accepted level and edge pulses.
module debounce_cell
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic grst,
    input  logic pin,
    input  logic db_bypass,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LIM_M1 = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          lim_m1_s;
    logic                   synced_s;
    logic                   differ_s;
    logic                   accept_s;

    // Metastability chain for the raw pin level
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
        end
    end

    // >= keeps a count left over from a longer limit from wrapping after bypass is set
    always_comb begin
        synced_s = sync_r[SYNC_STAGES-1];
        differ_s = synced_s ^ clean;
        if (db_bypass) begin
            lim_m1_s = {CW{1'b0}};
        end else begin
            lim_m1_s = LIM_M1;
        end
        accept_s = differ_s & (cnt_r >= lim_m1_s);
    end

    // Persistence counter, accepted level and one-cycle edge pulses
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            cnt_r <= {CW{1'b0}};
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            if (!differ_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (accept_s) begin
                cnt_r <= {CW{1'b0}};
                clean <= synced_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            rise <= accept_s & synced_s;
            fall <= accept_s & ~synced_s;
        end
    end

endmodule

// File: rtl/gpio_conditioner.sv
// Pin front end: chip-select-gated reset synchronizer plus per-pin debounce cells.
module gpio_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int NUM_PINS        = DEF_NUM_PINS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int RST_STAGES      = DEF_RST_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ncs,
    input  logic [NUM_PINS-1:0] pins_in,
    input  logic                db_bypass,
    output logic                core_rst,
    output logic                ready,
    output logic [NUM_PINS-1:0] pins_clean,
    output logic [NUM_PINS-1:0] rise,
    output logic [NUM_PINS-1:0] fall,
    output logic                any_edge
);

    logic                  grst_s;
    logic [RST_STAGES-1:0] rst_sync_r;

    assign grst_s = rst | ncs;

    // Reset release ripples through the chain; assertion is immediate
    always_ff @(posedge clk or posedge grst_s) begin
        if (grst_s) begin
            rst_sync_r <= {RST_STAGES{1'b0}};
        end else begin
            rst_sync_r <= {rst_sync_r[RST_STAGES-2:0], 1'b1};
        end
    end

    assign core_rst = ~rst_sync_r[RST_STAGES-1];
    assign ready    = rst_sync_r[RST_STAGES-1];
    assign any_edge = |{rise, fall};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk       (clk),
            .grst      (grst_s),
            .pin       (pins_in[i]),
            .db_bypass (db_bypass),
            .clean     (pins_clean[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule

// File: tb/tb_gpio_conditioner.sv
// Directed self-checking bench for gpio_conditioner with default parameters.
module tb_gpio_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        ncs;
    logic [16:0] pins_in;
    logic        db_bypass;
    logic        core_rst;
    logic        ready;
    logic [16:0] pins_clean;
    logic [16:0] rise;
    logic [16:0] fall;
    logic        any_edge;

    int checks   = 0;
    int failures = 0;

    gpio_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .ncs        (ncs),
        .pins_in    (pins_in),
        .db_bypass  (db_bypass),
        .core_rst   (core_rst),
        .ready      (ready),
        .pins_clean (pins_clean),
        .rise       (rise),
        .fall       (fall),
        .any_edge   (any_edge)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic glitch_seen;

    initial begin
        rst       = 1'b1;
        ncs       = 1'b0;
        pins_in   = 17'h00000;
        db_bypass = 1'b0;
        tick(3);
        check_val("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_clean", {15'd0, pins_clean}, 32'd0);
        check_val("rst_edges", {14'd0, rise, fall, any_edge}, 32'd0);

        // reset release: core_rst falls after the second edge
        rst = 1'b0;
        tick(1);
        check_val("rel_edge1_core_rst", {31'd0, core_rst}, 32'd1);
        tick(1);
        check_val("rel_edge2_core_rst", {31'd0, core_rst}, 32'd0);
        check_val("rel_edge2_ready", {31'd0, ready}, 32'd1);

        // clean debounce on pin 3: visible after E+9
        pins_in[3] = 1'b1;
        tick(9);
        check_val("deb_before_clean", {15'd0, pins_clean}, 32'd0);
        tick(1);
        check_val("deb_clean", {15'd0, pins_clean}, 32'h8);
        check_val("deb_rise", {15'd0, rise}, 32'h8);
        check_val("deb_any", {31'd0, any_edge}, 32'd1);
        tick(1);
        check_val("deb_rise_off", {15'd0, rise}, 32'd0);
        check_val("deb_any_off", {31'd0, any_edge}, 32'd0);
        check_val("deb_clean_hold", {15'd0, pins_clean}, 32'h8);

        // glitch on pin 0 of 5 cycles is rejected
        glitch_seen = 1'b0;
        pins_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            glitch_seen = glitch_seen | pins_clean[0] | rise[0] | fall[0];
        end
        pins_in[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            glitch_seen = glitch_seen | pins_clean[0] | rise[0] | fall[0];
        end
        check_val("glitch_rejected", {31'd0, glitch_seen}, 32'd0);

        // bypass: pin 16 falls after two edges
        pins_in[16] = 1'b1;
        tick(12);
        check_val("byp_pre_clean", {15'd0, pins_clean}, 32'h10008);
        db_bypass   = 1'b1;
        pins_in[16] = 1'b0;
        tick(1);
        check_val("byp_edge1_clean", {15'd0, pins_clean}, 32'h10008);
        tick(1);
        check_val("byp_edge2_fall", {15'd0, fall}, 32'd0);
        tick(1);
        check_val("byp_clean", {15'd0, pins_clean}, 32'h00008);
        check_val("byp_fall", {15'd0, fall}, 32'h10000);
        check_val("byp_rise", {15'd0, rise}, 32'd0);
        db_bypass = 1'b0;

        // multi-pin rise
        pins_in = 17'h00000;
        tick(12);
        check_val("multi_pre_clean", {15'd0, pins_clean}, 32'd0);
        pins_in = 17'h1FFFF;
        tick(9);
        check_val("multi_before_rise", {15'd0, rise}, 32'd0);
        tick(1);
        check_val("multi_rise", {15'd0, rise}, 32'h1FFFF);
        check_val("multi_clean", {15'd0, pins_clean}, 32'h1FFFF);
        check_val("multi_any", {31'd0, any_edge}, 32'd1);
        tick(1);
        check_val("multi_rise_off", {15'd0, rise}, 32'd0);
        check_val("multi_any_off", {31'd0, any_edge}, 32'd0);

        // bypass set with cnt=3 pending: accepted on the next edge
        pins_in = 17'h00000;
        tick(5);
        check_val("tog_pending_clean", {15'd0, pins_clean}, 32'h1FFFF);
        db_bypass = 1'b1;
        tick(1);
        check_val("tog_clean", {15'd0, pins_clean}, 32'd0);
        check_val("tog_fall", {15'd0, fall}, 32'h1FFFF);
        tick(1);

        // establish pin 4 stable high, then start pin 5 pending
        pins_in = 17'h00010;
        tick(3);
        check_val("ncs_pre_clean", {15'd0, pins_clean}, 32'h10);
        db_bypass = 1'b0;
        pins_in   = 17'h00030;
        tick(6);
        check_val("ncs_pending_clean", {15'd0, pins_clean}, 32'h10);
        ncs = 1'b1;
        #1;
        check_val("ncs_core_rst", {31'd0, core_rst}, 32'd1);
        check_val("ncs_ready", {31'd0, ready}, 32'd0);
        check_val("ncs_clean", {15'd0, pins_clean}, 32'd0);
        tick(2);
        ncs = 1'b0;
        tick(1);
        check_val("ncs_rel1_core_rst", {31'd0, core_rst}, 32'd1);
        tick(1);
        check_val("ncs_rel2_core_rst", {31'd0, core_rst}, 32'd0);
        tick(7);
        check_val("ncs_before_rise", {15'd0, rise}, 32'd0);
        tick(1);
        check_val("ncs_rise", {15'd0, rise}, 32'h30);
        check_val("ncs_clean_after", {15'd0, pins_clean}, 32'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_conditioner.md
Name: gpio_conditioner

Overview:
Parametrised front end between breakout-board pins and a project core, replacing the fixed 2-flop reset synchronizer and raw pin hookup of the current top-level wrapper.
- Reset path: chip-select-gated reset synchronizer with configurable depth.
- Pin path: NUM_PINS input channels, each with a metastability synchronizer, a per-pin debounce filter (bypassable at runtime) and one-cycle rise/fall edge pulses.
- Instantiated once per top-level wrapper; the core consumes core_rst, pins_clean and the edge pulses.

Parameters:
NUM_PINS, 17, number of conditioned input pins (1..34)
SYNC_STAGES, 2, synchronizer flops per pin (>=2)
RST_STAGES, 2, reset synchronizer flops (>=2)
DEBOUNCE_CYCLES, 8, consecutive cycles a new synced level must persist before acceptance (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ncs  input  1  chip select, active low; high holds block and core in reset
pins_in  input  NUM_PINS  raw asynchronous pin levels
db_bypass  input  1  1 = debounce bypassed (acceptance after 1 cycle); quasi-static
core_rst  output  1  active-high reset to core; async assert, sync deassert
ready  output  1  equals ~core_rst
pins_clean  output  NUM_PINS  debounced stable levels
rise  output  NUM_PINS  one-cycle pulse on stable 0->1
fall  output  NUM_PINS  one-cycle pulse on stable 1->0
any_edge  output  1  OR of all rise/fall bits, same cycle

Behaviour:
- Internal reset: grst = rst | ncs. All flops in the block use grst as async reset.
- Reset values:
  - core_rst = 1, ready = 0.
  - pins_clean, rise, fall, any_edge = 0.
  - Synchronizer and counter state = 0.
- Reset synchronizer:
  - RST_STAGES-flop shift chain, shifting in 1.
  - core_rst = ~last stage.
  - Deassert: core_rst falls on the RST_STAGES-th rising clk edge after grst falls.
  - Assert: immediate and asynchronous on grst rise, including mid-operation.
- Pin synchronizer: synced[i] equals pins_in[i] delayed by SYNC_STAGES edges.
- Debounce cell, per pin; state is stable[i] and cnt[i], width $clog2(DEBOUNCE_CYCLES+1). Each edge while grst = 0:
  - synced == stable: cnt <= 0.
  - synced != stable and cnt == LIMIT-1: stable <= synced, cnt <= 0. LIMIT = 1 if db_bypass, else DEBOUNCE_CYCLES.
  - Otherwise: cnt <= cnt+1.
- Glitch rejection: a glitch shorter than LIMIT synced cycles resets cnt and never changes stable.
- Latency: an input change set up before edge E appears on pins_clean after edge E+SYNC_STAGES+LIMIT-1. Minimum with bypass is SYNC_STAGES edges.
- Edge pulses:
  - rise[i] and fall[i] are registered and assert in the same cycle that pins_clean[i] changes, for exactly one cycle.
  - rise and fall are never both high on a pin.
- Bypass toggled while cnt > LIMIT-1: the compare uses >=, so the pending change is accepted on the next edge. No wrap-around.
- Simultaneous changes on multiple pins are handled independently; any_edge is high once.
- Pin activity while core_rst = 1: the pin path runs as soon as grst = 0, independent of core_rst. pins_clean is valid before ready.
- ncs rising mid-debounce: all state clears asynchronously. On release, the pin path restarts from 0. A pin held high is reported as a rise after the full latency.

Decomposition:
- Package gpio_cond_pkg:
  - Default constants DEF_NUM_PINS = 17, DEF_SYNC_STAGES = 2, DEF_RST_STAGES = 2, DEF_DEBOUNCE_CYCLES = 8.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module debounce_cell: one pin's synchronizer, counter, stable flop and edge flops, with parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated NUM_PINS times via generate.
- Top: reset synchronizer, any_edge reduction, ready.

Test Plan:
- Reset release: rst = 1 then 0 with ncs = 0 -> core_rst stays 1 through edge 1 and falls after edge 2. ready = 1 from then. All outputs 0 during reset.
- Clean debounce: pins_in[3] 0->1 before edge 10, held -> pins_clean[3] = 1 after edge 10+2+7 = 19. rise[3] = 1 for exactly that one cycle. any_edge matches.
- Glitch rejection: pins_in[0] high for 5 cycles, then low -> pins_clean[0], rise and fall stay 0 throughout.
- Bypass: db_bypass = 1, pins_in[16] 1->0 before edge 30 with pins_clean[16] = 1 -> pins_clean[16] = 0 and fall[16] = 1 after edge 32.
- Multi-pin: pins_in = 17'h1FFFF from 0 -> all rise bits assert together for one cycle. any_edge is a single pulse.
- Mid-operation ncs: ncs = 1 at cnt = 4 on a pending pin -> core_rst = 1 asynchronously and pins_clean = 0. After ncs = 0 with the pin still high, the rise arrives after the full 9-edge latency.
